gemm_acc_buffer: RTL and testbench
==================================

# gemm_acc_buffer

Accumulator scratchpad that answers the GEMM core's two accumulator ports: a combinational read port and a byte-lane-masked write port. It adds a same-cycle write-to-read bypass, a hardware clear engine that zeroes the array after reset or on request, and a host load port used by the load module to preload accumulator tiles. It sits between the GEMM core and the load path, owning the only copy of accumulator state.

## Interface
Parameters:
- ACC_WIDTH, 32, bits per accumulator lane
- ACC_DEPTH, 16, lanes per entry
- ACC_MEM_WIDTH, ACC_WIDTH*ACC_DEPTH (512), entry width
- ACC_MEM_WREN, ACC_MEM_WIDTH/8 (64), byte enables per entry
- ACC_IDX_WIDTH, 12, address port width
- ENTRIES, 2048, stored entries; valid addresses 0..ENTRIES-1

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  reset, asynchronous, active-low
- rd_addr  in  ACC_IDX_WIDTH  read address
- rd_ce  in  1  read enable
- rd_data  out  ACC_MEM_WIDTH  read data, same cycle
- wr_addr  in  ACC_IDX_WIDTH  write address
- wr_ce  in  1  write enable
- wr_we  in  ACC_MEM_WREN  byte enables; wr_we[i] covers wr_data[8i+7:8i]
- wr_data  in  ACC_MEM_WIDTH  write data
- ld_valid  in  1  host load request
- ld_ready  out  1  host load accepted this cycle
- ld_addr  in  ACC_IDX_WIDTH  host load address
- ld_data  in  ACC_MEM_WIDTH  host load data (full entry)
- clr_start  in  1  clear request pulse
- clr_busy  out  1  clear engine running
- clr_done  out  1  one-cycle pulse at end of clear
- wr_drop  out  1  sticky: GEMM write discarded during clear
- addr_err  out  1  sticky: access to address >= ENTRIES

## Operation
- FSM states IDLE, CLEAR, DONE. Reset → CLEAR with clr_ptr=0 (array zeroed automatically after reset).
- CLEAR: one entry per cycle, clr_ptr 0..ENTRIES-1, all bytes written 0; after clr_ptr==ENTRIES-1 → DONE. DONE: clr_done=1 for one cycle → IDLE.
- IDLE + clr_start → CLEAR, clr_ptr=0, wr_drop and addr_err cleared. clr_start outside IDLE ignored.
- clr_busy = (state==CLEAR).
- Write priority per cycle: clear engine > GEMM write > host load. In CLEAR, wr_ce with any wr_we bit set is discarded and sets wr_drop.
- GEMM write (IDLE/DONE, wr_ce=1): bytes with wr_we[i]=1 updated at the clock edge; others keep their value. wr_ce=1 with wr_we=0 is a no-op.
- ld_ready = (state!=CLEAR) && !(wr_ce && |wr_we). Handshake ld_valid&&ld_ready writes the full ld_data entry. ld_valid may be held across stalls; ld_addr/ld_data must be stable while ld_valid && !ld_ready.
- Out-of-range (address >= ENTRIES): write ignored, read returns 0, addr_err set (reads only when rd_ce=1).
- Read: rd_ce=0 → rd_data=0. rd_ce=1 → array content at rd_addr, with bypass: for each byte i, if the effective write this cycle (GEMM or accepted host load) targets rd_addr and enables byte i, rd_data byte i = new write byte. Clear-engine writes are not bypassed.

## Timing
- Read latency 0 (combinational from rd_addr, rd_ce, and write-port inputs); written data visible in the array from the next cycle, same cycle through bypass.
- Clear takes ENTRIES cycles in CLEAR plus 1 cycle in DONE; clr_done asserted in cycle ENTRIES+1 after clr_start is sampled.
- Reset values: clr_busy=1 (state CLEAR) from reset release, clr_done=0, wr_drop=0, addr_err=0, ld_ready=0, rd_data=0 while rd_ce=0. Array contents are undefined until the first clear completes.
- Reset asserted mid-clear or mid-load: FSM returns to CLEAR at clr_ptr 0; a load beat in flight is lost.
- Sticky flags set at the edge following the offending cycle.

## Structure
- Shared package (gemm_pkg): ACC_WIDTH, ACC_DEPTH, ACC_MEM_WIDTH, ACC_MEM_WREN, ACC_IDX_WIDTH, and the FSM state enum.
- One sub-module, gemm_acc_ram: ENTRIES x ACC_MEM_WIDTH array, one byte-masked write port, one asynchronous read port. Write mux, bypass, and FSM stay in the top.

## Test plan
- Reset release → clr_busy=1 for 2048 cycles, clr_done pulse in the next cycle; reading addr 5 returns 0.
- GEMM write addr 3, wr_we=64'h0000_0000_0000_000F, data lane0=32'hDEADBEEF, rest 0xFF → next-cycle read addr 3 gives lane0=DEADBEEF, other lanes unchanged (0).
- Same-cycle write addr 7 lane1=32'h12345678 (wr_we[7:4]=F) with rd_addr=7 → rd_data lane1=12345678 that cycle; rd_addr=8 the same cycle unaffected.
- ld_valid to addr 10 while GEMM writes → ld_ready=0; in the next cycle with no GEMM write → ld_ready=1, addr 10 holds ld_data.
- clr_start, then a GEMM write to addr 3 during CLEAR → write dropped, wr_drop=1; after clr_done, addr 3 reads 0.
- Read with rd_ce=1, rd_addr=12'h800 → rd_data=0, addr_err=1 from the next cycle; addr_err cleared by the next clr_start.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared accumulator-buffer widths and the clear-engine state encoding.
package gemm_pkg;
  localparam int ACC_WIDTH     = 32;
  localparam int ACC_DEPTH     = 16;
  localparam int ACC_MEM_WIDTH = ACC_WIDTH * ACC_DEPTH;
  localparam int ACC_MEM_WREN  = ACC_MEM_WIDTH / 8;
  localparam int ACC_IDX_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;
endpackage

// File: rtl/gemm_acc_buffer_if.sv
// Accumulator buffer ports: GEMM read/write, host load, clear control and status.
interface gemm_acc_buffer_if;
  import gemm_pkg::*;

  logic [ACC_IDX_WIDTH-1:0] rd_addr;
  logic                     rd_ce;
  logic [ACC_MEM_WIDTH-1:0] rd_data;
  logic [ACC_IDX_WIDTH-1:0] wr_addr;
  logic                     wr_ce;
  logic [ACC_MEM_WREN-1:0]  wr_we;
  logic [ACC_MEM_WIDTH-1:0] wr_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [ACC_IDX_WIDTH-1:0] ld_addr;
  logic [ACC_MEM_WIDTH-1:0] ld_data;
  logic                     clr_start;
  logic                     clr_busy;
  logic                     clr_done;
  logic                     wr_drop;
  logic                     addr_err;

  modport master (
    output rd_addr, rd_ce, wr_addr, wr_ce, wr_we, wr_data,
           ld_valid, ld_addr, ld_data, clr_start,
    input  rd_data, ld_ready, clr_busy, clr_done, wr_drop, addr_err
  );

  modport slave (
    input  rd_addr, rd_ce, wr_addr, wr_ce, wr_we, wr_data,
           ld_valid, ld_addr, ld_data, clr_start,
    output rd_data, ld_ready, clr_busy, clr_done, wr_drop, addr_err
  );
endinterface

// File: rtl/gemm_acc_ram.sv
// Accumulator storage: one byte-masked write port, one asynchronous read port.
// Contents are not reset; the clear engine in the parent zeroes them.
module gemm_acc_ram #(
  parameter int ENTRIES = 2048,
  parameter int AW      = 11,
  parameter int DW      = 512
) (
  input  logic            i_clk,
  input  logic [AW-1:0]   i_waddr,
  input  logic [DW/8-1:0] i_wbe,
  input  logic [DW-1:0]   i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata
);
  logic [DW-1:0] r_mem [ENTRIES];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DW/8; i++) begin
      if (i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/gemm_acc_buffer.sv
// Accumulator scratchpad: clear engine > GEMM write > host load, with
// same-cycle byte bypass from the effective GEMM/load write to the read port.
module gemm_acc_buffer
  import gemm_pkg::*;
#(
  parameter int ENTRIES = 2048
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  gemm_acc_buffer_if.slave   acc
);
  localparam int AW = $clog2(ENTRIES);
  localparam logic [ACC_IDX_WIDTH:0] LP_ENT  = (ACC_IDX_WIDTH+1)'(ENTRIES);
  localparam logic [AW-1:0]          LP_LAST = AW'(ENTRIES - 1);

  acc_state_e r_state;
  logic [AW-1:0] r_clr_ptr;
  logic r_clr_busy, r_clr_done, r_wr_drop, r_addr_err;

  logic w_gemm_wr, w_rd_oor, w_wr_oor, w_ld_oor, w_ld_ready, w_ld_fire, w_err_hit;
  logic [AW-1:0]            w_ram_addr;
  logic [ACC_MEM_WREN-1:0]  w_ram_be, w_byp_be;
  logic [ACC_MEM_WIDTH-1:0] w_ram_dat, w_byp_dat, w_ram_rdat, w_rd_dat;
  logic [ACC_IDX_WIDTH-1:0] w_byp_addr;

  assign w_gemm_wr  = acc.wr_ce && (|acc.wr_we);
  assign w_rd_oor   = {1'b0, acc.rd_addr} >= LP_ENT;
  assign w_wr_oor   = {1'b0, acc.wr_addr} >= LP_ENT;
  assign w_ld_oor   = {1'b0, acc.ld_addr} >= LP_ENT;
  assign w_ld_ready = (r_state != ST_CLEAR) && !w_gemm_wr;
  assign w_ld_fire  = acc.ld_valid && w_ld_ready;

  // Clear-engine writes never reach the bypass path (w_byp_be stays 0).
  always_comb begin
    w_ram_addr = '0;
    w_ram_be   = '0;
    w_ram_dat  = '0;
    w_byp_be   = '0;
    w_byp_dat  = acc.wr_data;
    w_byp_addr = acc.wr_addr;
    if (r_state == ST_CLEAR) begin
      w_ram_addr = r_clr_ptr;
      w_ram_be   = '1;
    end else if (w_gemm_wr) begin
      if (!w_wr_oor) begin
        w_ram_addr = acc.wr_addr[AW-1:0];
        w_ram_be   = acc.wr_we;
        w_ram_dat  = acc.wr_data;
        w_byp_be   = acc.wr_we;
      end
    end else if (w_ld_fire && !w_ld_oor) begin
      w_ram_addr = acc.ld_addr[AW-1:0];
      w_ram_be   = '1;
      w_ram_dat  = acc.ld_data;
      w_byp_be   = '1;
      w_byp_dat  = acc.ld_data;
      w_byp_addr = acc.ld_addr;
    end
  end

  gemm_acc_ram #(.ENTRIES(ENTRIES), .AW(AW), .DW(ACC_MEM_WIDTH)) u_ram (
    .i_clk   (ap_clk),
    .i_waddr (w_ram_addr),
    .i_wbe   (w_ram_be),
    .i_wdata (w_ram_dat),
    .i_raddr (acc.rd_addr[AW-1:0]),
    .o_rdata (w_ram_rdat)
  );

  always_comb begin
    w_rd_dat = '0;
    if (acc.rd_ce && !w_rd_oor) begin
      for (int i = 0; i < ACC_MEM_WREN; i++) begin
        w_rd_dat[8*i +: 8] = (w_byp_be[i] && (w_byp_addr == acc.rd_addr)) ?
                             w_byp_dat[8*i +: 8] : w_ram_rdat[8*i +: 8];
      end
    end
  end

  assign w_err_hit = (acc.rd_ce && w_rd_oor) ||
                     ((r_state != ST_CLEAR) && w_gemm_wr && w_wr_oor) ||
                     (w_ld_fire && w_ld_oor);

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_clr_busy <= 1'b1;
      r_clr_done <= 1'b0;
      r_wr_drop  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (acc.clr_start) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_ptr == LP_LAST) begin
            r_state    <= ST_DONE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + AW'(1);
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      if ((r_state == ST_IDLE) && acc.clr_start) begin
        r_wr_drop  <= 1'b0;
        r_addr_err <= 1'b0;
      end else begin
        if ((r_state == ST_CLEAR) && w_gemm_wr) r_wr_drop <= 1'b1;
        if (w_err_hit) r_addr_err <= 1'b1;
      end
    end
  end

  assign acc.rd_data  = w_rd_dat;
  assign acc.ld_ready = w_ld_ready;
  assign acc.clr_busy = r_clr_busy;
  assign acc.clr_done = r_clr_done;
  assign acc.wr_drop  = r_wr_drop;
  assign acc.addr_err = r_addr_err;
endmodule

// File: tb/tb_gemm_acc_buffer.sv
// Directed bench for gemm_acc_buffer: vector table plus clear/load/error sequences.
module tb_gemm_acc_buffer;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b0;
  always #5 ap_clk = ~ap_clk;

  gemm_acc_buffer_if acc();

  gemm_acc_buffer #(.ENTRIES(2048)) u_dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .acc    (acc.slave)
  );

  typedef struct {
    logic         wce;
    logic [11:0]  wa;
    logic [63:0]  we;
    logic [511:0] wd;
    logic         rce;
    logic [11:0]  ra;
    logic [511:0] exp_rd;
  } vec_t;

  vec_t vt[13];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic wce, input logic [11:0] wa, input logic [63:0] we,
                              input logic [511:0] wd, input logic rce, input logic [11:0] ra,
                              input logic [511:0] ex);
    vec_t v;
    v.wce = wce; v.wa = wa; v.we = we; v.wd = wd;
    v.rce = rce; v.ra = ra; v.exp_rd = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic idle_inputs();
    acc.wr_ce = 1'b0; acc.wr_we = '0; acc.wr_addr = '0; acc.wr_data = '0;
    acc.ld_valid = 1'b0; acc.clr_start = 1'b0;
  endtask

  logic [511:0] pat, ldp;
  int edges;
  logic busy_ok, drop_mid, ldr_mid;

  initial begin
    pat = {16{32'h0BADF00D}};
    ldp = {16{32'h600DCAFE}};
    vt[0]  = mk(1, 12'd3,    64'hF,  {{15{32'hFFFFFFFF}}, 32'hDEADBEEF}, 1, 12'd3, 512'hDEADBEEF);
    vt[1]  = mk(0, 12'd0,    64'h0,  '0, 1, 12'd3, 512'hDEADBEEF);
    vt[2]  = mk(1, 12'd7,    64'hF0, {{14{32'hAAAAAAAA}}, 32'h12345678, 32'h55555555}, 1, 12'd7,
                512'h12345678_00000000);
    vt[3]  = mk(0, 12'd0,    64'h0,  '0, 1, 12'd7, 512'h12345678_00000000);
    vt[4]  = mk(1, 12'd7,    64'hF0, {{14{32'hAAAAAAAA}}, 32'hCAFEF00D, 32'h55555555}, 1, 12'd8, '0);
    vt[5]  = mk(0, 12'd0,    64'h0,  '0, 1, 12'd7, 512'hCAFEF00D_00000000);
    vt[6]  = mk(0, 12'd0,    64'h0,  '0, 0, 12'd7, '0);
    vt[7]  = mk(1, 12'd7,    64'h0,  {16{32'hFFFFFFFF}}, 1, 12'd7, 512'hCAFEF00D_00000000);
    vt[8]  = mk(1, 12'd3,    64'h10, {16{32'h11111111}}, 1, 12'd3, 512'h11_DEADBEEF);
    vt[9]  = mk(0, 12'd0,    64'h0,  '0, 1, 12'd3, 512'h11_DEADBEEF);
    vt[10] = mk(1, 12'd2047, {64{1'b1}}, pat, 1, 12'd2047, pat);
    vt[11] = mk(0, 12'd0,    64'h0,  '0, 1, 12'd2047, pat);
    vt[12] = mk(1, 12'd5,    64'hFF00, {16{32'h77777777}}, 1, 12'd5,
                512'h77777777_77777777_00000000_00000000);

    idle_inputs();
    acc.rd_ce = 1'b0; acc.rd_addr = '0; acc.ld_addr = '0; acc.ld_data = '0;

    // Reset state
    #12;
    chk("rst_busy", acc.clr_busy, 1'b1);
    chk("rst_done", acc.clr_done, 1'b0);
    chk("rst_drop", acc.wr_drop, 1'b0);
    chk("rst_err",  acc.addr_err, 1'b0);
    chk("rst_ldrdy", acc.ld_ready, 1'b0);
    chk("rst_rd",   acc.rd_data, '0);
    @(negedge ap_clk); ap_rst = 1'b1;

    // Power-on clear: done must appear after exactly 2048 edges
    edges = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge ap_clk); #1;
      edges = k;
      if (acc.clr_done) break;
      if (!acc.clr_busy) busy_ok = 1'b0;
    end
    chk("por_edges", 512'(edges), 512'd2048);
    chk("por_busy_held", busy_ok, 1'b1);
    @(posedge ap_clk); #1;
    chk("por_done_pulse", acc.clr_done, 1'b0);
    chk("por_busy_end", acc.clr_busy, 1'b0);
    @(negedge ap_clk);
    acc.rd_ce = 1'b1; acc.rd_addr = 12'd5; #1;
    chk("por_rd5", acc.rd_data, '0);

    for (int i = 0; i < 13; i++) begin
      @(negedge ap_clk);
      acc.wr_ce = vt[i].wce; acc.wr_addr = vt[i].wa; acc.wr_we = vt[i].we; acc.wr_data = vt[i].wd;
      acc.rd_ce = vt[i].rce; acc.rd_addr = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_rd", i), acc.rd_data, vt[i].exp_rd);
    end

    // Host load stalled by a GEMM write, accepted the next cycle
    @(negedge ap_clk);
    acc.wr_ce = 1'b1; acc.wr_addr = 12'd20; acc.wr_we = '1; acc.wr_data = pat;
    acc.ld_valid = 1'b1; acc.ld_addr = 12'd10; acc.ld_data = ldp;
    acc.rd_ce = 1'b1; acc.rd_addr = 12'd10; #1;
    chk("ld_stall_rdy", acc.ld_ready, 1'b0);
    chk("ld_stall_rd", acc.rd_data, '0);
    @(negedge ap_clk);
    acc.wr_ce = 1'b0; acc.wr_we = '0; #1;
    chk("ld_go_rdy", acc.ld_ready, 1'b1);
    chk("ld_go_byp", acc.rd_data, ldp);
    @(negedge ap_clk);
    acc.ld_valid = 1'b0; #1;
    chk("ld_arr10", acc.rd_data, ldp);
    acc.rd_addr = 12'd20; #1;
    chk("ld_arr20", acc.rd_data, pat);

    // Requested clear with a dropped GEMM write and an ignored clr_start
    @(negedge ap_clk);
    acc.clr_start = 1'b1;
    edges = 0; drop_mid = 1'b0; ldr_mid = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge ap_clk); #1;
      edges = k;
      if (acc.clr_done) break;
      if (k == 1) acc.clr_start = 1'b0;
      if (k == 100) begin
        acc.wr_ce = 1'b1; acc.wr_addr = 12'd3; acc.wr_we = 64'hF; acc.wr_data = pat;
        ldr_mid = acc.ld_ready;
      end
      if (k == 101) begin
        drop_mid = acc.wr_drop;
        acc.wr_ce = 1'b0; acc.wr_we = '0;
      end
      if (k == 200) acc.clr_start = 1'b1;
      if (k == 201) acc.clr_start = 1'b0;
    end
    chk("clr_edges", 512'(edges), 512'd2049);
    chk("clr_ldrdy", ldr_mid, 1'b0);
    chk("clr_drop_set", drop_mid, 1'b1);
    chk("clr_drop_sticky", acc.wr_drop, 1'b1);
    @(negedge ap_clk);
    acc.rd_addr = 12'd3; #1;
    chk("clr_rd3", acc.rd_data, '0);
    acc.rd_addr = 12'd2047; #1;
    chk("clr_rd2047", acc.rd_data, '0);

    // Out-of-range accesses
    @(negedge ap_clk);
    acc.rd_addr = 12'h800;
    acc.wr_ce = 1'b1; acc.wr_addr = 12'h800; acc.wr_we = '1; acc.wr_data = pat; #1;
    chk("oor_rd", acc.rd_data, '0);
    chk("oor_err_pre", acc.addr_err, 1'b0);
    @(negedge ap_clk);
    idle_inputs(); acc.rd_addr = 12'd0; #1;
    chk("oor_err_set", acc.addr_err, 1'b1);
    chk("oor_wr_ignored", acc.rd_data, '0);
    @(negedge ap_clk);
    acc.clr_start = 1'b1;
    @(negedge ap_clk);
    acc.clr_start = 1'b0; #1;
    chk("err_cleared", acc.addr_err, 1'b0);
    chk("drop_cleared", acc.wr_drop, 1'b0);
    chk("clr_restart_busy", acc.clr_busy, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
